// File: rtl/fifo_write_control.sv
// Write-domain half of the CDC FIFO: binary/Gray write pointer, read-pointer
// synchroniser, and the full / almost_full / fill_level / overflow flags.
`timescale 1ns/1ps
module fifo_write_control #(
  parameter int unsigned ADDRESS_WIDTH         = 4,
  parameter int unsigned ALMOST_FULL_THRESHOLD = 12,
  parameter int unsigned SYNC_STAGES           = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_valid,
  output logic                     write_ready,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [ADDRESS_WIDTH:0]   write_pointer_gray,
  input  logic [ADDRESS_WIDTH:0]   read_pointer_gray,
  output logic                     full,
  output logic                     almost_full,
  output logic [ADDRESS_WIDTH:0]   fill_level,
  output logic                     overflow
);

  localparam int unsigned PW = ADDRESS_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rsync;
  logic [PW-1:0] rbin;
  logic [PW-1:0] fill_next;
  logic [PW-1:0] full_match;
  logic [PW-1:0] rq [SYNC_STAGES];
  logic          accept;

  assign accept        = write_valid & ~full;
  assign write_ready   = ~full;
  assign write_enable  = accept;
  assign write_address = wbin[ADDRESS_WIDTH-1:0];

  assign wbin_next  = wbin + PW'(accept);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign rsync      = rq[SYNC_STAGES-1];

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_match = {~rsync[PW-1:PW-2], rsync[PW-3:0]};
  assign fill_next  = wbin_next - rbin;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin[i] = ^(rsync >> i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wbin               <= '0;
      write_pointer_gray <= '0;
      full               <= 1'b0;
      almost_full        <= 1'b0;
      fill_level         <= '0;
      overflow           <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        rq[i] <= '0;
      end
    end else begin
      wbin               <= wbin_next;
      write_pointer_gray <= wgray_next;
      full               <= (wgray_next == full_match);
      fill_level         <= fill_next;
      almost_full        <= (fill_next >= PW'(ALMOST_FULL_THRESHOLD));
      if (write_valid & full) begin
        overflow <= 1'b1;
      end
      rq[0] <= read_pointer_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        rq[i] <= rq[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_control.sv
// Randomised scoreboard bench for fifo_write_control against an occupancy-count model.
`timescale 1ns/1ps
module tb_fifo_write_control;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int TH    = 12;
  localparam int S     = 2;

  logic          clock;
  logic          reset;
  logic          write_valid;
  logic          write_ready;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [PW-1:0] write_pointer_gray;
  logic [PW-1:0] read_pointer_gray;
  logic          full;
  logic          almost_full;
  logic [PW-1:0] fill_level;
  logic          overflow;

  fifo_write_control #(
    .ADDRESS_WIDTH(AW),
    .ALMOST_FULL_THRESHOLD(TH),
    .SYNC_STAGES(S)
  ) dut (
    .clock(clock),
    .reset(reset),
    .write_valid(write_valid),
    .write_ready(write_ready),
    .write_enable(write_enable),
    .write_address(write_address),
    .write_pointer_gray(write_pointer_gray),
    .read_pointer_gray(read_pointer_gray),
    .full(full),
    .almost_full(almost_full),
    .fill_level(fill_level),
    .overflow(overflow)
  );

  typedef struct packed {
    logic          rdy;
    logic          we;
    logic [AW-1:0] addr;
    logic [PW-1:0] wpg;
    logic          full;
    logic          af;
    logic [PW-1:0] fill;
    logic          ovf;
  } snap_t;

  snap_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model: total words accepted, total words read, and the read count as seen
  // through the synchroniser delay.
  int wcount;
  int rcount;
  int rhist[S];
  bit m_full;
  bit m_af;
  bit m_ovf;
  int m_fill;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [PW-1:0] gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v % PMOD);
    return b ^ (b >> 1);
  endfunction

  task automatic model_edge(input bit wv, input bit rst);
    int synced;
    if (rst) begin
      wcount = 0;
      for (int i = 0; i < S; i++) rhist[i] = 0;
      m_full = 0; m_af = 0; m_fill = 0; m_ovf = 0;
    end else begin
      synced = rhist[S-1];
      if (wv && m_full) m_ovf = 1;
      if (wv && !m_full) wcount++;
      m_fill = wcount - synced;
      m_full = (m_fill == DEPTH);
      m_af   = (m_fill >= TH);
      for (int i = S - 1; i > 0; i--) rhist[i] = rhist[i-1];
      rhist[0] = rcount;
    end
  endtask

  // Drive one cycle, queue the snapshot expected mid-cycle, then advance the model.
  task automatic cycle(input bit wv, input bit rst, input bit chk);
    snap_t e;
    write_valid       = wv;
    reset             = rst;
    read_pointer_gray = gray(rcount);
    if (chk) begin
      e.rdy  = !m_full;
      e.we   = wv && !m_full;
      e.addr = AW'(wcount % DEPTH);
      e.wpg  = gray(wcount);
      e.full = m_full;
      e.af   = m_af;
      e.fill = PW'(m_fill);
      e.ovf  = m_ovf;
      sb.push_back(e);
    end
    @(posedge clock);
    model_edge(wv, rst);
    #1;
  endtask

  task automatic do_reset();
    rcount = 0;
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    snap_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("write_ready",        32'(write_ready),        32'(e.rdy));
      cmp("write_enable",       32'(write_enable),       32'(e.we));
      cmp("write_address",      32'(write_address),      32'(e.addr));
      cmp("write_pointer_gray", 32'(write_pointer_gray), 32'(e.wpg));
      cmp("full",               32'(full),               32'(e.full));
      cmp("almost_full",        32'(almost_full),        32'(e.af));
      cmp("fill_level",         32'(fill_level),         32'(e.fill));
      cmp("overflow",           32'(overflow),           32'(e.ovf));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bit wv;
    wcount = 0; rcount = 0;
    for (int i = 0; i < S; i++) rhist[i] = 0;
    m_full = 0; m_af = 0; m_fill = 0; m_ovf = 0;
    write_valid = 1'b1; reset = 1'b1; read_pointer_gray = '0;

    // Reset held two cycles with a push request pending
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);

    // Fill to depth, then push while full
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1);

    // One read in the other domain releases full after the synchroniser delay
    rcount = 1;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Wrap twice with the reader trailing
    do_reset();
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 1'b0, 1'b1);
      rcount = (wcount > 4) ? wcount - 4 : 0;
      cycle(1'b0, 1'b0, 1'b1);
    end

    // Reset in the middle of a fill
    do_reset();
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Random pushes, reads and occasional resets
    for (int k = 0; k < 2000; k++) begin
      wv = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 299) == 0) begin
        rcount = 0;
        cycle(wv, 1'b1, 1'b1);
      end else begin
        if (rcount < wcount && $urandom_range(0, 1) == 1) rcount++;
        cycle(wv, 1'b0, 1'b1);
      end
    end

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_control.md
Name: fifo_write_control

Overview:
Write-side pointer and flag logic for the CDC FIFO. Sits directly upstream of the dual-port RAM, in the write clock domain. Accepts push requests from the producer and drives the RAM write_address and write_enable. Publishes a Gray-coded write pointer to the read domain, synchronises the read domain's Gray pointer back, and computes full, almost_full, fill level and overflow.

Parameters:
ADDRESS_WIDTH, 4, RAM address width; depth = 2**ADDRESS_WIDTH; legal range 2..8.
ALMOST_FULL_THRESHOLD, 12, almost_full asserts when fill_level >= this value; range 1..depth.
SYNC_STAGES, 2, flops in the read-pointer synchroniser; range 2..4.

Ports:
clock  input  1  write-domain clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
write_valid  input  1  producer push request.
write_ready  output  1  equals ~full; a push is accepted when write_valid & write_ready.
write_enable  output  1  to RAM; combinational, equals write_valid & ~full.
write_address  output  ADDRESS_WIDTH  to RAM; the low ADDRESS_WIDTH bits of the binary write pointer.
write_pointer_gray  output  ADDRESS_WIDTH+1  registered Gray write pointer, sent to the read domain.
read_pointer_gray  input  ADDRESS_WIDTH+1  Gray read pointer from the read domain; asynchronous to clock.
full  output  1  registered full flag.
almost_full  output  1  registered flag, set when fill_level >= ALMOST_FULL_THRESHOLD.
fill_level  output  ADDRESS_WIDTH+1  registered, pessimistic occupancy, range 0..depth.
overflow  output  1  sticky flag; set by a push attempt while full.

Behaviour:
- State: binary pointer wbin (ADDRESS_WIDTH+1 bits), Gray register wgray, synchroniser chain rq[0..SYNC_STAGES-1], and registered full, almost_full, fill_level, overflow.
- Reset (synchronous, dominates all other inputs): every register is cleared to 0.
  - Resulting outputs: write_ready=1, write_enable=write_valid, write_address=0, write_pointer_gray=0, full=0, almost_full=0, fill_level=0, overflow=0.
  - The read domain must be reset in the same window; this block does not check for that.
- Accept: wbin_next = wbin + (write_valid & ~full), wrapping modulo 2**(ADDRESS_WIDTH+1).
  - wgray <= wbin_next ^ (wbin_next >> 1). The Gray pointer changes the cycle after an accept.
  - write_address shows the slot being written in the same cycle write_enable is high.
- Synchroniser: rq[0] <= read_pointer_gray, rq[i] <= rq[i-1]. No other logic may read read_pointer_gray. rsync = rq[SYNC_STAGES-1].
- Full: full <= (gray(wbin_next) == {~rsync[MSB:MSB-1], rsync[MSB-2:0]}).
  - Full asserts on the same edge that accepts the depth-th outstanding word.
  - Full deasserts SYNC_STAGES+1 edges after read_pointer_gray advances.
- Fill level: rbin = Gray-to-binary(rsync). fill_level <= (wbin_next - rbin) mod 2**(ADDRESS_WIDTH+1).
  - Never exceeds depth.
  - Conservative: it may overstate occupancy during synchroniser latency, and never understates it.
- almost_full <= (next fill_level >= ALMOST_FULL_THRESHOLD). It updates on the same edge as fill_level.
- Overflow: if write_valid & full, the push is dropped, the RAM is not written, the pointer holds, and overflow <= 1. Overflow clears only on reset.
- Simultaneous events:
  - A push in the cycle a read pointer change reaches rsync uses the new rsync.
  - A push in the last free slot sets full on that edge, even if a read is in flight.
- Wrap-around: after a push at write_address = depth-1, the next address is 0 and wbin's MSB toggles. The full/empty distinction comes from the MSB only.
- Reset mid-operation: pointer contents are discarded; data already in the RAM is not cleared.
- Fixed latencies: zero cycles from write_valid to write_enable; one cycle from accept to write_pointer_gray/fill_level update.

Test Plan:
- Reset: assert reset 2 cycles with write_valid=1 -> after release all outputs 0 except write_ready=1; no pointer advance during reset.
- Fill (ADDRESS_WIDTH=4): read_pointer_gray=0, write_valid=1 for 16 cycles.
  - write_address steps 0..15; write_pointer_gray steps 1,3,2,6,...
  - almost_full rises on the edge after the 12th accept.
  - full=1 and fill_level=16 on the edge after the 16th accept; write_pointer_gray=5'b11000.
- Overflow: while full, hold write_valid=1 for 3 cycles -> write_enable=0, write_address stays 0, pointer unchanged, overflow=1 and stays 1.
- Drain release: from full, drive read_pointer_gray=5'b00001 -> full stays 1 for 2 edges, drops on the 3rd; fill_level=15; one push is then accepted at write_address=0.
- Wrap: interleave pushes with a read pointer trailing by 4 for 40 pushes -> address wraps 15->0 twice, full never asserts, fill_level stays <=5, pointer MSB toggles at push 16 and 32.
- Reset mid-fill: after 7 pushes, pulse reset 1 cycle -> next edge shows write_pointer_gray=0, fill_level=0; next accepted push uses write_address=0.
